// File: rtl/alu_op_sequencer.sv
// Sequencer for the 4-bit ALU datapath. It latches a command, drives the operands and the
// mux select, waits SETTLE_CYCLES, then captures mux_y into the result and the accumulator.
module alu_op_sequencer #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic       cmd_acc,
   input  logic       acc_clr,
   output logic [3:0] op_a,
   output logic [3:0] op_b,
   output logic [1:0] mux_sel,
   input  logic [3:0] mux_y,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [3:0] res_data,
   output logic       res_zero,
   output logic [3:0] acc_out,
   output logic [1:0] dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
   // valid is never dropped without a transfer, and data is held while valid is high.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic [3:0] acc;
   logic       accept;
   logic       capture;
   logic       res_xfer;

   assign accept   = cmd_valid & cmd_ready;
   assign capture  = (state == EXEC) && (cnt == 4'd0);
   assign res_xfer = res_valid & res_ready;
   assign acc_out  = acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)   state_nxt = EXEC;
         EXEC:    if (capture)  state_nxt = DONE;
         DONE:    if (res_xfer) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state == IDLE);
      res_valid = (state == DONE);
      dbg_state = state;
   end

   // A clear arriving with a cmd_acc command is visible to that command's operand A.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a     <= 4'd0;
         op_b     <= 4'd0;
         mux_sel  <= 2'd0;
         cnt      <= 4'd0;
         res_data <= 4'd0;
         res_zero <= 1'b1;
         acc      <= 4'd0;
      end else begin
         if (accept) begin
            op_a    <= cmd_acc ? (acc_clr ? 4'd0 : acc) : cmd_a;
            op_b    <= cmd_b;
            mux_sel <= cmd_op;
            cnt     <= CNT_INIT;
         end else if (state == EXEC && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end

         if (capture) begin
            res_data <= mux_y;
            res_zero <= (mux_y == 4'd0);
            acc      <= mux_y;
         end else if (state == IDLE && acc_clr) begin
            acc <= 4'd0;
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: one instance with SETTLE_CYCLES=1 and one with 4, a
// behavioural result mux per instance, and a queue-based scoreboard per instance.
module tb_alu_op_sequencer;

   logic       clk;
   logic       rst_n;
   logic [1:0] cmd_valid_v;
   logic [1:0] cmd_op;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic       cmd_acc;
   logic       acc_clr;
   logic       res_ready;

   logic       rdy1, rv1, rz1, rdy4, rv4, rz4;
   logic [3:0] opa1, opb1, y1, rd1, acc1, opa4, opb4, y4, rd4, acc4;
   logic [1:0] sel1, sel4, st1, st4;

   int total = 0;
   int bad = 0;
   int xfer1 = 0;
   logic [3:0] exp_q1[$];
   logic [3:0] exp_q4[$];

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   alu_op_sequencer #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_v[0]), .cmd_ready(rdy1),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc), .acc_clr(acc_clr),
      .op_a(opa1), .op_b(opb1), .mux_sel(sel1), .mux_y(y1), .res_valid(rv1),
      .res_ready(res_ready), .res_data(rd1), .res_zero(rz1), .acc_out(acc1), .dbg_state(st1)
   );

   alu_op_sequencer #(.SETTLE_CYCLES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_v[1]), .cmd_ready(rdy4),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc), .acc_clr(acc_clr),
      .op_a(opa4), .op_b(opb4), .mux_sel(sel4), .mux_y(y4), .res_valid(rv4),
      .res_ready(res_ready), .res_data(rd4), .res_zero(rz4), .acc_out(acc4), .dbg_state(st4)
   );

   function automatic logic [3:0] alu_mux(input logic [1:0] s, input logic [3:0] a,
                                          input logic [3:0] b);
      case (s)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a + b;
         default: return a - b;
      endcase
   endfunction

   assign y1 = alu_mux(sel1, opa1, opb1);
   assign y4 = alu_mux(sel4, opa4, opb4);

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: pop on every result transfer
   always @(negedge clk) begin : mon1
      logic [3:0] e;
      if (rst_n && rv1 && res_ready) begin
         xfer1++;
         if (exp_q1.size() == 0) begin
            chk("unexpected_result1", 1, 0);
         end else begin
            e = exp_q1.pop_front();
            chk("res_data1", int'(rd1), int'(e));
            chk("res_zero1", int'(rz1), int'(e == 4'd0));
            chk("acc_out1", int'(acc1), int'(e));
         end
      end
   end

   always @(negedge clk) begin : mon4
      logic [3:0] e;
      if (rst_n && rv4 && res_ready) begin
         if (exp_q4.size() == 0) begin
            chk("unexpected_result4", 1, 0);
         end else begin
            e = exp_q4.pop_front();
            chk("res_data4", int'(rd4), int'(e));
            chk("res_zero4", int'(rz4), int'(e == 4'd0));
            chk("acc_out4", int'(acc4), int'(e));
         end
      end
   end

   // Driver tasks
   task automatic send(input int which, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic accf, input logic clr,
                       input logic [3:0] exp, input bit push);
      bit got;
      got = 0;
      @(posedge clk); #1;
      cmd_valid_v[which] = 1'b1;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = accf; acc_clr = clr;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if ((which == 1) ? rdy4 : rdy1) begin
            got = 1;
            break;
         end
      end
      if (!got) chk("accept_timeout", 0, 1);
      @(posedge clk);
      if (push) begin
         if (which == 1) exp_q4.push_back(exp);
         else exp_q1.push_back(exp);
      end
      #1;
      cmd_valid_v = 2'b00;
      acc_clr = 1'b0;
   endtask

   task automatic wait_idle1();
      bit got;
      got = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rdy1) begin
            got = 1;
            break;
         end
      end
      if (!got) chk("idle_timeout", 0, 1);
   endtask

   task automatic clear_acc();
      @(posedge clk); #1;
      acc_clr = 1'b1;
      @(posedge clk); #1;
      acc_clr = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int x0;
      bit seen;
      rst_n = 1'b0;
      cmd_valid_v = 2'b00;
      cmd_op = 2'd0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_acc = 1'b0; acc_clr = 1'b0;
      res_ready = 1'b1;

      // Reset check
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", rdy1, 1);
      chk("rst_res_valid", rv1, 0);
      chk("rst_res_data", rd1, 0);
      chk("rst_res_zero", rz1, 1);
      chk("rst_acc", acc1, 0);
      chk("rst_op_a", opa1, 0);
      chk("rst_op_b", opb1, 0);
      chk("rst_mux_sel", sel1, 0);
      chk("rst_cmd_ready4", rdy4, 1);

      // Single op: 9 + 8 = 1 (mod 16)
      send(0, 2'd2, 4'd9, 4'd8, 1'b0, 1'b0, 4'd1, 1);
      chk("single_op_a", opa1, 9);
      chk("single_op_b", opb1, 8);
      chk("single_sel", sel1, 2);
      @(negedge clk);
      chk("single_valid_c1", rv1, 0);
      @(negedge clk);
      chk("single_valid_c2", rv1, 1);
      chk("single_data_c2", rd1, 1);
      chk("single_zero_c2", rz1, 0);
      chk("single_acc_c2", acc1, 1);
      @(negedge clk);
      chk("single_ready_after", rdy1, 1);
      chk("single_valid_after", rv1, 0);

      // Accumulate chain: 3, 6, 9, then 9-9 = 0
      clear_acc();
      @(negedge clk);
      chk("chain_acc_clear", acc1, 0);
      send(0, 2'd2, 4'd0, 4'd3, 1'b1, 1'b0, 4'd3, 1); wait_idle1();
      send(0, 2'd2, 4'd0, 4'd3, 1'b1, 1'b0, 4'd6, 1); wait_idle1();
      send(0, 2'd2, 4'd0, 4'd3, 1'b1, 1'b0, 4'd9, 1); wait_idle1();
      send(0, 2'd3, 4'd0, 4'd9, 1'b1, 1'b0, 4'd0, 1); wait_idle1();
      chk("chain_final_zero", rz1, 1);

      // Back-pressure: 12 & 10 = 8 held for 10 cycles
      res_ready = 1'b0;
      send(0, 2'd0, 4'd12, 4'd10, 1'b0, 1'b0, 4'd8, 1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rv1) begin
            seen = 1;
            break;
         end
      end
      chk("bp_valid_rise", seen, 1);
      cmd_valid_v[0] = 1'b1; cmd_op = 2'd1; cmd_a = 4'd3; cmd_b = 4'd4;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_data_hold", rd1, 8);
         chk("bp_valid_hold", rv1, 1);
         chk("bp_cmd_ready", rdy1, 0);
         chk("bp_op_a_hold", opa1, 12);
      end
      @(posedge clk); #1;
      cmd_valid_v = 2'b00;
      x0 = xfer1;
      res_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("bp_one_transfer", xfer1 - x0, 1);
      chk("bp_queue_empty", exp_q1.size(), 0);

      // Settle of 4: 5 | 10 = 15 captured exactly 4 edges after accept
      send(1, 2'd1, 4'd5, 4'd10, 1'b0, 1'b0, 4'd15, 1);
      chk("settle_sel_n", sel4, 1);
      chk("settle_op_a", opa4, 5);
      chk("settle_op_b", opb4, 10);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         chk("settle_no_valid", rv4, 0);
         chk("settle_sel_hold", sel4, 1);
      end
      @(posedge clk); #1;
      chk("settle_valid_n4", rv4, 1);
      chk("settle_data_n4", rd4, 15);
      repeat (3) @(negedge clk);
      chk("settle_queue_empty", exp_q4.size(), 0);

      // Reset abort during the 2nd EXEC cycle
      send(1, 2'd1, 4'd5, 4'd10, 1'b0, 1'b0, 4'd15, 0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("abort_cmd_ready", rdy4, 1);
      chk("abort_res_valid", rv4, 0);
      chk("abort_res_data", rd4, 0);
      chk("abort_res_zero", rz4, 1);
      chk("abort_acc", acc4, 0);
      chk("abort_op_a", opa4, 0);
      chk("abort_op_b", opb4, 0);
      chk("abort_mux_sel", sel4, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("abort_no_valid", rv4, 0);
      end

      // Clear collision: acc=7, clear together with a cmd_acc command, 0 | 2 = 2
      send(0, 2'd1, 4'd7, 4'd0, 1'b0, 1'b0, 4'd7, 1); wait_idle1();
      chk("coll_acc_pre", acc1, 7);
      send(0, 2'd1, 4'd5, 4'd2, 1'b1, 1'b1, 4'd2, 1);
      chk("coll_op_a", opa1, 0);
      wait_idle1();
      chk("coll_acc_post", acc1, 2);

      repeat (3) @(negedge clk);
      chk("final_q1_empty", exp_q1.size(), 0);
      chk("final_q4_empty", exp_q4.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
